// File: rtl/data_memory_pkg.sv
// data_memory_pkg: access-size encodings and byte-lane helpers for data_memory_port
package data_memory_pkg;
  typedef enum logic [1:0] {SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2, SIZE_D = 2'd3} size_e;
  function automatic int laneCount(input int dataWidth);
    return dataWidth / 8;
  endfunction
  // contiguous group of 2^size lanes starting at offset; covers up to eight lanes
  function automatic logic [7:0] byteEnable(input logic [1:0] size, input logic [2:0] offset);
    return ~(8'hff << (4'd1 << size)) << offset;
  endfunction
endpackage

// File: rtl/data_memory_port_if.sv
// data_memory_port_if: request/response handshake bundle between the load/store unit and data_memory_port
interface data_memory_port_if #(parameter int ADDR_WIDTH = 17, parameter int DATA_WIDTH = 32);
  logic reqValid, reqReady, reqWrite, reqUnsigned, respValid, respReady, respError;
  logic [1:0] reqSize;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] writeData, readData;
  modport master(
    output reqValid, reqWrite, reqSize, reqUnsigned, address, writeData, respReady,
    input reqReady, respValid, readData, respError
  );
  modport slave(
    input reqValid, reqWrite, reqSize, reqUnsigned, address, writeData, respReady,
    output reqReady, respValid, readData, respError
  );
endinterface

// File: rtl/data_memory_array.sv
// data_memory_array: single-port RAM with per-byte write enables and a registered read
module data_memory_array
  import data_memory_pkg::*;
#(
  parameter int DEPTH = 32768,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic enable,
  input  logic [laneCount(DATA_WIDTH)-1:0] writeEnable,
  input  logic [$clog2(DEPTH)-1:0] wordAddr,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // one access per edge: enabled lanes are written and the old word is read out
  always_ff @(posedge clk)
    if (enable) begin
      for (int i = 0; i < laneCount(DATA_WIDTH); i++)
        if (writeEnable[i]) mem[wordAddr][i*8 +: 8] <= writeData[i*8 +: 8];
      readData <= mem[wordAddr];
    end
endmodule

// File: rtl/data_memory_port.sv
// data_memory_port: handshaked byte/half/word(/dword) load-store port; DMEM_MISALIGN_CHECK_EN rejects misaligned accesses instead of aligning them
module data_memory_port
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  data_memory_port_if.slave bus
);
  localparam int LANES = laneCount(DATA_WIDTH);
  localparam int OFF_W = $clog2(LANES);
  localparam int WORD_W = ADDR_WIDTH - OFF_W;
  localparam logic [0:0] EMPTY = 1'b0, FULL = 1'b1;
  logic [0:0] state;
  logic accept, sizeIllegal, reqError, unsignedQ, loadQ, errorQ;
  logic [1:0] sizeQ;
  logic [OFF_W-1:0] offset, sizeLow, laneOffset, offsetQ;
  logic [LANES-1:0] writeEnable;
  logic [DATA_WIDTH-1:0] laneData, ramData, shifted, sizeMask, signMask;
  assign bus.respValid = state == FULL;
  assign bus.reqReady = !bus.respValid || bus.respReady;
  assign bus.respError = errorQ;
  assign accept = bus.reqValid && bus.reqReady;
  assign offset = bus.address[OFF_W-1:0];
  assign sizeLow = ~({OFF_W{1'b1}} << bus.reqSize);
  assign sizeIllegal = DATA_WIDTH == 32 && bus.reqSize == SIZE_D;
`ifdef DMEM_MISALIGN_CHECK_EN
  assign reqError = sizeIllegal || |(offset & sizeLow);
  assign laneOffset = offset;
`else
  assign reqError = sizeIllegal;
  assign laneOffset = offset & ~sizeLow;
`endif
  assign writeEnable = accept && bus.reqWrite && !reqError ? LANES'(byteEnable(bus.reqSize, 3'(laneOffset))) : '0;
  assign laneData = bus.writeData << {laneOffset, 3'b000};
  data_memory_array #(.DEPTH(1 << WORD_W), .DATA_WIDTH(DATA_WIDTH)) ram (
    .clk(clk),
    .enable(accept),
    .writeEnable(writeEnable),
    .wordAddr(bus.address[ADDR_WIDTH-1:OFF_W]),
    .writeData(laneData),
    .readData(ramData)
  );
  // align the selected lanes to bit 0 and extend from the top bit of the access
  always_comb begin
    shifted = ramData >> {offsetQ, 3'b000};
    sizeMask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - (8 << sizeQ));
    signMask = sizeMask ^ (sizeMask >> 1);
    bus.readData = loadQ ? (shifted & sizeMask) | (!unsignedQ && |(shifted & signMask) ? ~sizeMask : '0) : '0;
  end
  // EMPTY/FULL response slot; an accept always refills it, a bare transfer drains it
  always_ff @(posedge clk)
    if (reset) begin
      state <= EMPTY;
      loadQ <= 1'b0;
      errorQ <= 1'b0;
    end else if (accept) begin
      state <= FULL;
      loadQ <= !bus.reqWrite && !reqError;
      errorQ <= reqError;
      sizeQ <= reqError ? SIZE_B : bus.reqSize;
      offsetQ <= laneOffset;
      unsignedQ <= bus.reqUnsigned;
    end else if (bus.respReady) state <= EMPTY;
endmodule

// File: tb/tb_data_memory_port.sv
// tb_data_memory_port: directed scoreboard bench for data_memory_port
module tb_data_memory_port;
  import data_memory_pkg::*;
  typedef struct {logic [31:0] data; logic err; string tag;} exp_t;
  logic clk = 1'b0, reset = 1'b1;
  int checks = 0, fails = 0, cyc = 0, pushed = 0, popped = 0, base = 0;
  int respCycle[$];
  exp_t sb[$];
  exp_t e;
  logic [31:0] dv;
  data_memory_port_if #(.ADDR_WIDTH(17), .DATA_WIDTH(32)) bus();
  data_memory_port #(.ADDR_WIDTH(17), .DATA_WIDTH(32)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic checkBit(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask
  always @(negedge clk)
    if (!reset && bus.respValid && bus.respReady) begin
      respCycle.push_back(cyc);
      checkBit("resp_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        popped++;
        check({e.tag, "_data"}, bus.readData, e.data);
        checkBit({e.tag, "_err"}, bus.respError, e.err);
      end
    end
  task automatic req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                     input logic [16:0] a, input logic [31:0] d, input logic [31:0] ed, input logic ee);
    int n = 0;
    bus.reqValid = 1'b1;
    bus.reqWrite = w;
    bus.reqSize = sz;
    bus.reqUnsigned = u;
    bus.address = a;
    bus.writeData = d;
    sb.push_back('{ed, ee, tag});
    pushed++;
    while (!bus.reqReady && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.reqReady) checkBit({tag, "_ready_timeout"}, bus.reqReady, 1'b1);
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
  endtask
  initial begin
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqSize = 2'd0; bus.reqUnsigned = 1'b0;
    bus.address = '0; bus.writeData = '0; bus.respReady = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkBit("rst_respValid", bus.respValid, 1'b0);
    check("rst_readData", bus.readData, 32'h0);
    checkBit("rst_respError", bus.respError, 1'b0);
    checkBit("rst_reqReady", bus.reqReady, 1'b1);
    bus.respReady = 1'b1;
    req("st_word", 1'b1, SIZE_W, 1'b0, 17'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    req("ld_word", 1'b0, SIZE_W, 1'b0, 17'h100, 32'h0, 32'hDEADBEEF, 1'b0);
    checkBit("ld_latency_valid", bus.respValid, 1'b1);
    check("ld_latency_data", bus.readData, 32'hDEADBEEF);
    req("st_byte", 1'b1, SIZE_B, 1'b0, 17'h101, 32'h7F, 32'h0, 1'b0);
    req("ldb_s_101", 1'b0, SIZE_B, 1'b0, 17'h101, 32'h0, 32'h0000007F, 1'b0);
    req("ldh_u_100", 1'b0, SIZE_H, 1'b1, 17'h100, 32'h0, 32'h00007FEF, 1'b0);
    req("ldb_s_103", 1'b0, SIZE_B, 1'b0, 17'h103, 32'h0, 32'hFFFFFFDE, 1'b0);
    req("ldh_s_102", 1'b0, SIZE_H, 1'b0, 17'h102, 32'h0, 32'hFFFFDEAD, 1'b0);
    req("ldb_u_103", 1'b0, SIZE_B, 1'b1, 17'h103, 32'h0, 32'h000000DE, 1'b0);
    req("st_dword", 1'b1, SIZE_D, 1'b0, 17'h100, 32'h11111111, 32'h0, 1'b1);
    req("ld_dword", 1'b0, SIZE_D, 1'b0, 17'h100, 32'h0, 32'h0, 1'b1);
    req("ld_after_dword", 1'b0, SIZE_W, 1'b0, 17'h100, 32'h0, 32'hDEAD7FEF, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
    req("ld_mis_102", 1'b0, SIZE_W, 1'b0, 17'h102, 32'h0, 32'h0, 1'b1);
    req("st_mis_101", 1'b1, SIZE_H, 1'b0, 17'h101, 32'hAAAA, 32'h0, 1'b1);
    req("ld_after_mis", 1'b0, SIZE_W, 1'b0, 17'h100, 32'h0, 32'hDEAD7FEF, 1'b0);
`else
    req("ld_mis_102", 1'b0, SIZE_W, 1'b0, 17'h102, 32'h0, 32'hDEAD7FEF, 1'b0);
    req("ldh_mis_101", 1'b0, SIZE_H, 1'b1, 17'h101, 32'h0, 32'h00007FEF, 1'b0);
`endif
    @(posedge clk); #1;
    bus.respReady = 1'b0;
    req("ld_stall", 1'b0, SIZE_W, 1'b0, 17'h100, 32'h0, 32'hDEAD7FEF, 1'b0);
    bus.reqValid = 1'b1; bus.reqWrite = 1'b0; bus.reqSize = SIZE_B; bus.reqUnsigned = 1'b1; bus.address = 17'h100;
    sb.push_back('{32'h000000EF, 1'b0, "ld_release"});
    pushed++;
    for (int i = 0; i < 3; i++) begin
      checkBit("stall_reqReady", bus.reqReady, 1'b0);
      checkBit("stall_respValid", bus.respValid, 1'b1);
      check("stall_readData", bus.readData, 32'hDEAD7FEF);
      @(posedge clk); #1;
    end
    bus.respReady = 1'b1;
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
    checkBit("release_respValid", bus.respValid, 1'b1);
    check("release_readData", bus.readData, 32'h000000EF);
    for (int i = 0; i < 16; i++) begin
      dv = 32'(i) * 32'h01020304 ^ 32'hA5A55A5A;
      req("burst_st", 1'b1, SIZE_W, 1'b0, 17'(32'h400 + 4 * i), dv, 32'h0, 1'b0);
    end
    @(posedge clk); #1;
    base = respCycle.size();
    for (int i = 0; i < 16; i++) begin
      dv = 32'(i) * 32'h01020304 ^ 32'hA5A55A5A;
      req("burst_ld", 1'b0, SIZE_W, 1'b0, 17'(32'h400 + 4 * i), 32'h0, dv, 1'b0);
    end
    @(posedge clk); #1;
    check("burst_count", respCycle.size() - base, 32'd16);
    if (respCycle.size() - base >= 16) check("burst_span", respCycle[base + 15] - respCycle[base], 32'd15);
    bus.respReady = 1'b0;
    req("st_rst", 1'b1, SIZE_W, 1'b0, 17'h200, 32'hCAFEF00D, 32'h0, 1'b0);
    void'(sb.pop_back());
    pushed--;
    checkBit("full_before_rst", bus.respValid, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkBit("post_rst_respValid", bus.respValid, 1'b0);
    checkBit("post_rst_reqReady", bus.reqReady, 1'b1);
    check("post_rst_readData", bus.readData, 32'h0);
    bus.respReady = 1'b1;
    req("ld_rst", 1'b0, SIZE_W, 1'b0, 17'h200, 32'h0, 32'hCAFEF00D, 1'b0);
    for (int n = 0; n < 20 && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    check("sb_drained", sb.size(), 32'd0);
    check("resp_total", popped, pushed);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/data_memory_port.md
# data_memory_port

Parametrised, handshaked data-memory port for the RISC-V core's load/store unit. It supports byte, half and word (optionally dword) accesses with byte-lane write enables and sign/zero-extended loads. Reads are registered, and one outstanding response is held under back-pressure. It sits between the core's memory stage and a byte-enabled synchronous RAM.

## Interface
- ADDR_WIDTH, 17: byte-address width. Array depth is 2^(ADDR_WIDTH − log2(DATA_WIDTH/8)) words.
- DATA_WIDTH, 32: word width, 32 or 64.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- reqValid  in  1  request present.
- reqReady  out  1  port can accept a request.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DATA_WIDTH = 64).
- reqUnsigned  in  1  load zero-extends when 1, sign-extends when 0.
- address  in  ADDR_WIDTH  byte address.
- writeData  in  DATA_WIDTH  store data, right-aligned.
- respValid  out  1  response present.
- respReady  in  1  consumer takes the response.
- readData  out  DATA_WIDTH  extended load result; 0 for stores and errors.
- respError  out  1  access was rejected (illegal size or misaligned).

## Operation
- Request transfer: reqValid && reqReady at a rising edge. Response transfer: respValid && respReady at a rising edge.
- reqReady = !respValid || respReady, combinational. This allows one request per cycle while the consumer keeps up.
- Every accepted request, load or store, produces exactly one response.
- Lane offset = address[log2(DATA_WIDTH/8)−1:0]. Word index = the remaining upper address bits.
- Stores:
  - Byte enables are a contiguous group of 2^reqSize bytes starting at the lane offset.
  - Store data is shifted left by offset×8.
  - The RAM is written at the acceptance edge. The response has readData = 0 and respError = 0.
- Loads:
  - The RAM word is read synchronously at the acceptance edge. Size, offset and unsigned flag are registered alongside it.
  - readData = the selected lanes shifted down, then sign- or zero-extended to DATA_WIDTH.
- Illegal size (3 with DATA_WIDTH = 32):
  - No write occurs.
  - respError = 1 and readData = 0.
- Single RAM port, one access per edge. A load accepted the cycle after a store to the same word returns the stored data.
- Response hold: while respValid && !respReady, readData and respError stay stable and no request is accepted.
- State machine:
  - EMPTY (respValid = 0) → FULL on accept.
  - FULL stays FULL on a simultaneous response transfer plus new accept.
  - FULL → EMPTY on a response transfer with no accept.
- Reset values: respValid = 0, readData = 0, respError = 0, so reqReady = 1 after reset.
- RAM contents are not reset.
- Reset asserted while FULL: the pending response is discarded. A store already accepted stays committed.

## Timing
- Acceptance at edge N → respValid = 1 during cycle N+1, so load latency is 1 cycle.
- Sustained throughput is 1 request per cycle while respReady = 1.
- Under stall, the response from edge N persists until the first edge where respReady = 1. A new request can be accepted on that same edge.
- reqReady is combinational on respValid and respReady. The request inputs have no combinational path to any output.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined:
  - An access whose offset is not a multiple of 2^reqSize is rejected: no write, respError = 1, readData = 0.
- DMEM_MISALIGN_CHECK_EN undefined:
  - Offset bits below the access size are forced to 0, so the access is silently aligned.
  - respError is raised only for an illegal size.

## Structure
- Package data_memory_pkg holds:
  - size encodings SIZE_B, SIZE_H, SIZE_W, SIZE_D;
  - a lane-count function;
  - a byte-enable generation function.
- Sub-module data_memory_array: byte-enabled, synchronous-read, single-port RAM. Parameters: depth and DATA_WIDTH. It takes a DATA_WIDTH/8 write-enable vector.
- Handshake, state, alignment checking and extraction live in the top level.

## Test plan
- Store word 0xDEADBEEF to 0x100, then load word from 0x100 → respValid 1 cycle after accept, readData = 0xDEADBEEF, respError = 0.
- Store byte 0x7F to 0x101 over the previous word, then signed load byte 0x101, unsigned load half 0x100, signed load byte 0x103:
  - 0x101 → 0x0000007F;
  - 0x100 → 0x00007FEF;
  - 0x103 → 0xFFFFFFDE.
- Hold respReady = 0 for 3 cycles after a load:
  - reqReady = 0 and readData stable;
  - raising respReady together with a new reqValid accepts the new request on that edge.
- Load word at 0x102:
  - with DMEM_MISALIGN_CHECK_EN → respError = 1, readData = 0;
  - without it → word from 0x100 is returned, respError = 0.
- Back-to-back 16 loads with respReady held at 1 → 16 responses on 16 consecutive cycles, in order.
- Assert reset while FULL → respValid = 0 and reqReady = 1 on the next cycle. A store accepted before the reset reads back correctly.
